// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin arbiter sharing one DRAM command path
// between NREQ requesters, one word (read or write) per transaction.
// Optional watchdog enabled by defining DRAM_ARB_TIMEOUT_EN; the default
// build has no watchdog and arb_err tied low.
module dram_req_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef DRAM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1023
`endif
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wen,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  input  logic                     init_done,
  input  logic                     rf_req,
  output logic                     dREN,
  output logic                     dWEN,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  input  logic                     ram_done,
  output logic                     arb_err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_lat_wen;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [NREQ-1:0]    r_req_done;
  logic               r_dren;
  logic               r_dwen;
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_grant;
  logic [IDX_W-1:0]   w_next_ptr;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
  logic [9:0]         r_wd_cnt;
  logic               r_arb_err;
`endif

  // Pick the first requesting index starting at the round-robin pointer
  always_comb begin : p_rr_pick
    logic [IDX_W-1:0] v_idx;
    w_found   = 1'b0;
    w_win_idx = '0;
    v_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = IDX_W'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req[v_idx]) begin
        w_found   = 1'b1;
        w_win_idx = v_idx;
      end
    end
  end

  assign w_grant    = init_done & ~rf_req & w_found;
  assign w_next_ptr = (r_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_lat_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_req_done  <= '0;
      r_dren      <= 1'b0;
      r_dwen      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
      r_wd_cnt    <= '0;
      r_arb_err   <= 1'b0;
`endif
    end else begin
      r_req_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_BUSY;
            r_gnt_idx   <= w_win_idx;
            r_lat_wen   <= wen[w_win_idx];
            r_ram_addr  <= addr[32'(w_win_idx) * ADDR_W +: ADDR_W];
            r_ram_wdata <= wdata[32'(w_win_idx) * DATA_W +: DATA_W];
            r_dren      <= ~wen[w_win_idx];
            r_dwen      <= wen[w_win_idx];
            r_busy      <= 1'b1;
`ifdef DRAM_ARB_TIMEOUT_EN
            r_wd_cnt    <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (ram_done) begin
            r_state    <= S_DONE;
            r_dren     <= 1'b0;
            r_dwen     <= 1'b0;
            r_req_done <= NREQ'(1) << r_gnt_idx;
            if (!r_lat_wen) begin
              r_rdata <= ram_rdata;
            end
          end
`ifdef DRAM_ARB_TIMEOUT_EN
          // Give up on a stalled DRAM path: complete with zero data and flag it
          else if (r_wd_cnt == WD_LAST) begin
            r_state    <= S_DONE;
            r_dren     <= 1'b0;
            r_dwen     <= 1'b0;
            r_req_done <= NREQ'(1) << r_gnt_idx;
            r_rdata    <= '0;
            r_arb_err  <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
        end
        default: begin
          r_state <= S_IDLE;
          r_dren  <= 1'b0;
          r_dwen  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_done  = r_req_done;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign dREN      = r_dren;
  assign dWEN      = r_dwen;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
`ifdef DRAM_ARB_TIMEOUT_EN
  assign arb_err   = r_arb_err;
`else
  assign arb_err   = 1'b0;
`endif

endmodule
